// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - unified single-port memory shared by round-robin arbitrated requesters
//
// One grant per clock; the granted access is performed on the edge and its
// response is registered on that same edge, so op_valid appears in the cycle
// after the grant. A port whose response is currently on op_valid is not
// eligible, which keeps its still-held request from being granted twice.
//
// Optional feature macro: SHARED_MEM_BOUNDS_CHECK_EN
//   defined   - accesses at or above SIZE_IN_BYTES do not write, return 0 and
//               set the sticky op_err flag
//   undefined - upper address bits are ignored (addresses wrap), no op_err port
//
// Ports (port k uses bit k, bits [32k+31:32k] and bits [4k+3:4k]):
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-high reset of all control state
//   ip_req_rd    per-port read request
//   ip_req_wr    per-port write request
//   ip_req_addr  per-port byte address, bits [1:0] ignored
//   ip_req_mask  per-port write byte enables
//   ip_req_data  per-port write data
//   op_valid     per-port one-cycle completion pulse
//   op_data      per-port read data, zero unless the matching op_valid is high
//   op_err       sticky out-of-range flag (bounds-check build only)

module shared_mem_arbiter #(
   parameter int NUM_PORTS     = 2,
   parameter int SIZE_IN_BYTES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PORTS-1:0]      ip_req_rd,
   input  logic [NUM_PORTS-1:0]      ip_req_wr,
   input  logic [32*NUM_PORTS-1:0]   ip_req_addr,
   input  logic [4*NUM_PORTS-1:0]    ip_req_mask,
   input  logic [32*NUM_PORTS-1:0]   ip_req_data,
   output logic [NUM_PORTS-1:0]      op_valid,
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
   output logic [32*NUM_PORTS-1:0]   op_data,
   output logic                      op_err
`else
   output logic [32*NUM_PORTS-1:0]   op_data
`endif
);

   localparam int AW    = $clog2(SIZE_IN_BYTES);
   localparam int WORDS = SIZE_IN_BYTES / 4;
   localparam int IW    = AW - 2;
   localparam int PW    = $clog2(NUM_PORTS);

   // Memory array: never reset, contents survive a reset pulse.
   logic [31:0]          mem [WORDS];

   logic [PW-1:0]        ptr;
   logic [NUM_PORTS-1:0] elig;

   logic                 gnt_found;
   int                   gnt_idx;
   int                   ptr_next;
   logic                 gnt_rd;
   logic                 gnt_wr;
   logic [31:0]          gnt_addr;
   logic [3:0]           gnt_mask;
   logic [31:0]          gnt_data;
   logic [IW-1:0]        gnt_word;
   logic                 do_write;
   logic [31:0]          rd_word;
   logic                 unused_addr_bits;

   // The port whose response is on op_valid this cycle was granted last
   // cycle and is still holding that request, so it sits out one cycle.
   assign elig = (ip_req_rd | ip_req_wr) & ~op_valid;

   // Round-robin search starting at ptr; the selected port's request fields
   // are muxed out in the same pass.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = 0;
      gnt_rd    = 1'b0;
      gnt_wr    = 1'b0;
      gnt_addr  = '0;
      gnt_mask  = '0;
      gnt_data  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!gnt_found && elig[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
            gnt_rd    = ip_req_rd[idx];
            gnt_wr    = ip_req_wr[idx];
            gnt_addr  = ip_req_addr[idx*32 +: 32];
            gnt_mask  = ip_req_mask[idx*4 +: 4];
            gnt_data  = ip_req_data[idx*32 +: 32];
         end
      end
   end

   assign ptr_next = (gnt_idx == NUM_PORTS - 1) ? 0 : gnt_idx + 1;
   assign gnt_word = gnt_addr[AW-1:2];

`ifdef SHARED_MEM_BOUNDS_CHECK_EN
   logic gnt_oob;
   assign gnt_oob          = (gnt_addr >> AW) != 32'd0;
   assign do_write         = gnt_found & gnt_wr & ~gnt_oob;
   assign rd_word          = gnt_oob ? 32'h0 : mem[gnt_word];
   // Only the byte-offset bits are left unconsumed here.
   assign unused_addr_bits = ^gnt_addr[1:0];
`else
   assign do_write         = gnt_found & gnt_wr;
   assign rd_word          = mem[gnt_word];
   // Byte offset and bits above the memory size do not select a word.
   assign unused_addr_bits = ^{gnt_addr[31:AW], gnt_addr[1:0]};
`endif

   // Control state is async-reset; the memory is written only outside reset
   // and is deliberately absent from the reset branch. rd_word is sampled
   // before the write lands, giving read-before-write for rd+wr requests.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= '0;
         op_valid <= '0;
         op_data  <= '0;
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
         op_err   <= 1'b0;
`endif
      end else begin
         op_valid <= '0;
         op_data  <= '0;
         if (gnt_found) begin
            op_valid[gnt_idx]          <= 1'b1;
            op_data[gnt_idx*32 +: 32]  <= gnt_rd ? rd_word : 32'h0;
            ptr                        <= PW'(ptr_next);
         end
         if (do_write) begin
            for (int b = 0; b < 4; b++) begin
               if (gnt_mask[b]) mem[gnt_word][8*b +: 8] <= gnt_data[8*b +: 8];
            end
         end
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
         if (gnt_found && gnt_oob) op_err <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - scoreboard bench for shared_mem_arbiter (2 ports, 64 bytes)

module tb_shared_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ip_req_rd, ip_req_wr;
   logic [63:0] ip_req_addr, ip_req_data;
   logic [7:0]  ip_req_mask;
   logic [1:0]  op_valid;
   logic [63:0] op_data;
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
   logic        op_err;
`endif

   logic        rd_a [2];
   logic        wr_a [2];
   logic [31:0] addr_a [2];
   logic [31:0] data_a [2];
   logic [3:0]  mask_a [2];

   assign ip_req_rd   = {rd_a[1], rd_a[0]};
   assign ip_req_wr   = {wr_a[1], wr_a[0]};
   assign ip_req_addr = {addr_a[1], addr_a[0]};
   assign ip_req_data = {data_a[1], data_a[0]};
   assign ip_req_mask = {mask_a[1], mask_a[0]};

   always #5 clk = ~clk;

   shared_mem_arbiter #(.NUM_PORTS(2), .SIZE_IN_BYTES(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .ip_req_rd   (ip_req_rd),
      .ip_req_wr   (ip_req_wr),
      .ip_req_addr (ip_req_addr),
      .ip_req_mask (ip_req_mask),
      .ip_req_data (ip_req_data),
      .op_valid    (op_valid),
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
      .op_data     (op_data),
      .op_err      (op_err)
`else
      .op_data     (op_data)
`endif
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [31:0] mdl [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int p, input logic [31:0] e);
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Reference read of the model word an access to addr would hit.
   function automatic logic [31:0] model_rd(input logic [31:0] addr);
      logic oob;
      oob = 1'b0;
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
      oob = (addr >= 32'd64);
`endif
      return oob ? 32'h0 : mdl[addr[5:2]];
   endfunction

   // Scoreboard: every op_valid pulse pops its port's queue.
   always @(negedge clk) begin
      if (!reset) begin
         check("onehot", 32'($countones(op_valid) <= 1), 32'd1);
         for (int p = 0; p < 2; p++) begin
            if (op_valid[p]) begin
               if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0))
                  check($sformatf("unexp_p%0d", p), 32'(op_valid[p]), 32'd0);
               else if (p == 0)
                  check("rsp_p0", op_data[31:0], q0.pop_front());
               else
                  check("rsp_p1", op_data[63:32], q1.pop_front());
            end else begin
               check($sformatf("idle_data_p%0d", p), op_data[p*32 +: 32], 32'h0);
            end
         end
      end
   end

   task automatic do_req(input int p, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, output int lat);
      logic [31:0] e;
      logic        oob;
      oob = 1'b0;
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
      oob = (addr >= 32'd64);
`endif
      e = rd ? model_rd(addr) : 32'h0;
      if (wr && !oob)
         for (int b = 0; b < 4; b++)
            if (mask[b]) mdl[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      push_exp(p, e);
      rd_a[p] = rd; wr_a[p] = wr; addr_a[p] = addr; mask_a[p] = mask; data_a[p] = data;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!op_valid[p] && lat < 20);
      if (!op_valid[p]) check($sformatf("tmo_p%0d", p), 32'd0, 32'd1);
      rd_a[p] = 1'b0; wr_a[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int lat, l0, l1;
      reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
         rd_a[p] = 0; wr_a[p] = 0; addr_a[p] = 0; mask_a[p] = 0; data_a[p] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(op_valid), 32'd0);
      check("rst_data_lo", op_data[31:0], 32'h0);
      check("rst_data_hi", op_data[63:32], 32'h0);
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
      check("rst_err", 32'(op_err), 32'd0);
`endif
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_valid", 32'(op_valid), 32'd0);
      end

      // write then cross-port read, partial write, rd+wr
      do_req(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, lat);
      check("lat_wr", 32'(lat), 32'd1);
      do_req(1, 1, 0, 32'h10, 4'h0, 32'h0, lat);
      check("lat_rd", 32'(lat), 32'd1);
      do_req(0, 0, 1, 32'h10, 4'h1, 32'h000000AA, lat);
      do_req(1, 1, 0, 32'h10, 4'h0, 32'h0, lat);
      do_req(0, 1, 1, 32'h10, 4'hF, 32'h12345678, lat);
      do_req(1, 1, 0, 32'h10, 4'h0, 32'h0, lat);

      // lone requester back to back: one completion every 2 cycles
      do_req(0, 1, 0, 32'h10, 4'h0, 32'h0, lat);
      for (int i = 0; i < 2; i++) begin
         do_req(0, 1, 0, 32'h10, 4'h0, 32'h0, lat);
         check("b2b_lat", 32'(lat), 32'd2);
      end

      // two ports at once: completions on consecutive cycles
      @(negedge clk);
      fork
         do_req(0, 0, 1, 32'h20, 4'hF, 32'h11112222, l0);
         do_req(1, 0, 1, 32'h24, 4'hF, 32'h33334444, l1);
      join
      check("pair_wr_lat", 32'(l0 + l1), 32'd3);
      @(negedge clk);
      fork
         do_req(0, 1, 0, 32'h24, 4'h0, 32'h0, l0);
         do_req(1, 1, 0, 32'h20, 4'h0, 32'h0, l1);
      join
      check("pair_rd_lat", 32'(l0 + l1), 32'd3);

      // fairness from reset with both ports requesting continuously
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rd_a[0] = 1; addr_a[0] = 32'h20;
      rd_a[1] = 1; addr_a[1] = 32'h24;
      for (int i = 0; i < 3; i++) begin
         push_exp(0, model_rd(32'h20));
         push_exp(1, model_rd(32'h24));
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("fair_%0d", i), 32'(op_valid), (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      rd_a[0] = 0; rd_a[1] = 0;

      // reset right after a grant: response dropped, P back to 0
      for (int v = 1; v >= 0; v--) begin
         @(negedge clk);
         @(negedge clk);
         addr_a[0] = 32'h20; addr_a[1] = 32'h10;
         rd_a[v] = 1;
         @(posedge clk);
         #1 reset = 1'b1;
         @(negedge clk);
         check($sformatf("midrst_valid_v%0d", v), 32'(op_valid), 32'd0);
         check($sformatf("midrst_data_v%0d", v), op_data[63:32] | op_data[31:0], 32'h0);
         rd_a[0] = 1; rd_a[1] = 1;
         push_exp(0, model_rd(32'h20));
         push_exp(1, model_rd(32'h10));
         reset = 1'b0;
         @(negedge clk);
         check($sformatf("rr_first_v%0d", v), 32'(op_valid), 32'd1);
         rd_a[0] = 0;
         @(negedge clk);
         check($sformatf("rr_second_v%0d", v), 32'(op_valid), 32'd2);
         rd_a[1] = 0;
      end

      // out-of-range read
      @(negedge clk);
      do_req(0, 0, 1, 32'h00, 4'hF, 32'hCAFEF00D, lat);
      do_req(1, 1, 0, 32'h100, 4'h0, 32'h0, lat);
`ifdef SHARED_MEM_BOUNDS_CHECK_EN
      check("oob_err", 32'(op_err), 32'd1);
`endif

      repeat (3) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Shared single-port memory with a round-robin arbiter serving NUM_PORTS independent requesters, e.g. instruction fetch and load/store. It replaces the separate instruction and data memories in the SoC with one unified memory. Each port keeps the existing request/valid/mask semantics. Accesses are pipelined: one grant per cycle, and each response is registered one cycle after its grant.

## Interface
- NUM_PORTS, 2, number of requester ports (2..8)
- SIZE_IN_BYTES, 64, memory size; a power of two and at least 8
- Port k occupies bit k of 1-bit buses, bits [32k+31:32k] of 32-bit buses, and bits [4k+3:4k] of mask buses.
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all control state
- ip_req_rd  input  NUM_PORTS  per-port read request
- ip_req_wr  input  NUM_PORTS  per-port write request
- ip_req_addr  input  32*NUM_PORTS  per-port byte address; bits [1:0] ignored
- ip_req_mask  input  4*NUM_PORTS  per-port byte-enable for writes
- ip_req_data  input  32*NUM_PORTS  per-port write data
- op_valid  output  NUM_PORTS  one-cycle completion pulse per port
- op_data  output  32*NUM_PORTS  read data; valid only while the matching op_valid is high
- op_err  output  1  sticky out-of-range flag; present only with the bounds-check macro

## Operation
- Request handshake:
  - A port is requesting when its rd or wr bit is 1.
  - It must hold addr, mask, data and the rd/wr bits stable until it sees its op_valid.
  - It may present a new request in the same cycle that op_valid is high.
- Eligibility: a port is eligible in cycle N if it is requesting and was not granted in cycle N-1. This masks the held request of the port currently receiving its response.
- Arbitration:
  - Round-robin from priority pointer P; the first eligible port in order P, P+1, … (mod NUM_PORTS) is granted.
  - After a grant to port k, P becomes (k+1) mod NUM_PORTS.
  - P is unchanged on idle cycles.
  - P resets to 0.
- Grant action, on the clock edge:
  - Word index = addr[log2(SIZE_IN_BYTES)-1:2].
  - Write: bytes with mask=1 are updated.
  - Read: the pre-edge word is captured into the response register.
  - rd and wr both set: the write is performed, and op_data returns the pre-write word.
  - Write responses drive op_data = 0.
- Response: the registered grant id drives exactly one op_valid bit high for one cycle. op_data for that port equals the captured word; all other ports' op_data = 0.
- Memory contents are not cleared by reset and are preserved across reset.

## Timing
- Reset values: op_valid = 0, op_data = 0, op_err = 0, P = 0, no pending response.
- Latency: a request granted at edge N gives op_valid high in cycle N+1. A lone requester issuing back-to-back requests sees one completion every 2 cycles.
- Throughput: up to one completion per cycle when two or more ports are requesting.
- Worst-case wait: NUM_PORTS cycles from first eligible to grant.
- Write-then-read ordering: a write granted at edge N is visible to any read granted at edge N+1 or later, from any port.
- Reset asserted mid-operation:
  - Any pending response is dropped; no op_valid is issued.
  - A write already committed at a completed edge stays committed.
  - After reset is released, requesters re-present their requests and are re-arbitrated from P = 0.

## Configuration
- SHARED_MEM_BOUNDS_CHECK_EN defined:
  - A granted access with addr ≥ SIZE_IN_BYTES performs no write.
  - It returns op_data = 0 with the normal op_valid pulse.
  - It sets op_err = 1, which stays set until reset.
- SHARED_MEM_BOUNDS_CHECK_EN undefined:
  - Upper address bits are ignored, so addresses wrap modulo SIZE_IN_BYTES.
  - The op_err port is absent.

## Test plan
- Reset release with all ports idle (NUM_PORTS=2): all op_valid stay 0 for 10 cycles and op_data = 0.
- Write, then read back:
  - Port 0 writes 0xDEADBEEF to 0x10 with mask 0xF → op_valid[0] at N+1.
  - Port 1 then reads 0x10 → op_data[1] = 0xDEADBEEF one cycle after its grant.
- Partial write: write 0x000000AA to 0x10 with mask 0x1 over 0xDEADBEEF, then read 0x10 → 0xDEADBEAA.
- Fairness: both ports request continuously from reset → grants alternate 0,1,0,1, and op_valid alternates every cycle.
- Reset mid-flight: assert reset in the cycle after a grant to port 1 → no op_valid[1]; after release, the re-presented request completes normally.
- Out-of-range access: with the macro, a read of 0x100 (SIZE_IN_BYTES=64) → op_data = 0 and op_err = 1. Without the macro, the same read returns the word stored at 0x00.
